// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared constants, decoder state encoding and event record for
//            the PS/2 key event controller.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_BYTE   = 8'hE0;
    localparam logic [7:0] PS2_BRK_BYTE   = 8'hF0;
    localparam int         EVENT_W        = 10;
    localparam int         PS2_FRAME_BITS = 11;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_ext     = 2'd1;
    localparam logic [1:0] c_st_brk     = 2'd2;
    localparam logic [1:0] c_st_ext_brk = 2'd3;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 line synchroniser, glitch filter, 11-bit frame shifter and
//            inter-edge timeout. Parity is enforced only when the macro
//            PS2_PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       byte_tick,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int c_filt_w = $clog2(FILTER_LEN + 1);
    localparam int c_to_w   = $clog2(TIMEOUT_CYC + 1);

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {ps2data, ps2clk};

    // Bit 0 is ps2clk, bit 1 is ps2data; both lines get identical treatment.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic                r_s1;
            logic                r_s2;
            logic                r_lvl;
            logic [c_filt_w-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_filt_w'(FILTER_LEN - 1)) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic              r_clk_prev;
    logic              r_busy;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [c_to_w-1:0] r_to_cnt;
    logic              r_tick;
    logic [7:0]        r_byte;
    logic              r_err;
    logic              w_fall;
    logic              w_par_ok;

    assign w_fall = r_clk_prev & ~w_filt[0];

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_par};
`else
    logic w_par_unused;
    assign w_par_unused = r_par;
    assign w_par_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
            r_busy     <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_tick     <= 1'b0;
            r_byte     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_clk_prev <= w_filt[0];
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (!r_busy) begin
                    // A high start bit is line noise, not a frame.
                    if (!w_filt[1]) begin
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 4'd1;
                    end
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {w_filt[1], r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par     <= w_filt[1];
                    r_bit_cnt <= 4'd10;
                end else if (r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                    if (w_filt[1] && w_par_ok) begin
                        r_tick <= 1'b1;
                        r_byte <= r_shift;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (r_busy) begin
                if (r_to_cnt == c_to_w'(TIMEOUT_CYC - 1)) begin
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_err     <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign byte_tick = r_tick;
    assign byte_data = r_byte;
    assign frame_err = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_ctrl
// Brief    : PS/2 scan-code receiver with E0/F0 prefix decoder and show-ahead
//            key event FIFO. Optional parity checking via PS2_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       frame_err
);

    localparam int c_depth = 1 << FIFO_AW;

    logic       w_byte_tick;
    logic [7:0] w_byte;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .byte_tick (w_byte_tick),
        .byte_data (w_byte),
        .frame_err (frame_err)
    );

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_push;
    ps2_event_t w_push_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_byte_tick) begin
            if (w_byte == PS2_EXT_BYTE) begin
                if (r_state == c_st_idle) begin
                    w_state_nxt = c_st_ext;
                end
            end else if (w_byte == PS2_BRK_BYTE) begin
                case (r_state)
                    c_st_idle: w_state_nxt = c_st_brk;
                    c_st_ext:  w_state_nxt = c_st_ext_brk;
                    default:   w_state_nxt = r_state;
                endcase
            end else begin
                w_state_nxt = c_st_idle;
            end
        end
    end

    always_comb begin
        w_push         = w_byte_tick && (w_byte != PS2_EXT_BYTE) && (w_byte != PS2_BRK_BYTE);
        w_push_ev.ext  = (r_state == c_st_ext) || (r_state == c_st_ext_brk);
        w_push_ev.brk  = (r_state == c_st_brk) || (r_state == c_st_ext_brk);
        w_push_ev.code = w_byte;
    end

    ps2_event_t         r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    ps2_event_t         w_head;

    assign event_valid = (r_count != '0);
    assign w_full      = (r_count == (FIFO_AW + 1)'(c_depth));
    assign w_pop       = event_valid && event_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset, so the head is masked until it holds an event.
    assign w_head      = r_mem[r_rd_ptr];
    assign event_code  = event_valid ? w_head.code : 8'h00;
    assign event_ext   = event_valid ? w_head.ext  : 1'b0;
    assign event_break = event_valid ? w_head.brk  : 1'b0;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_ctrl
// Brief    : Directed self-checking bench for ps2_key_event_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_ctrl;

    localparam int FIFO_AW     = 2;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 5000;
    localparam int HALF        = 20;
    localparam int LAT         = FILTER_LEN + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic       overflow;
    logic       ovf_clr;
    logic       frame_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ferr_cnt = 0;
    logic [9:0] got[$];

    ps2_key_event_ctrl #(
        .FIFO_AW     (FIFO_AW),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2clk      (ps2clk),
        .ps2data     (ps2data),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_code  (event_code),
        .event_ext   (event_ext),
        .event_break (event_break),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: log accepted events and frame_err pulses.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (event_valid && event_ready) got.push_back({event_ext, event_break, event_code});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip_par,
                                             input logic stop);
        return {stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic d);
        ps2data = d;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
        send_bits(frame_of(b, flip_par, stop), 11);
        ps2data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int fbase;
        logic [10:0] fr;

        ps2clk      = 1'b1;
        ps2data     = 1'b1;
        event_ready = 1'b0;
        ovf_clr     = 1'b0;
        do_reset();

        chk("rst_valid",    event_valid, 0);
        chk("rst_code",     event_code,  0);
        chk("rst_ext",      event_ext,   0);
        chk("rst_break",    event_break, 0);
        chk("rst_overflow", overflow,    0);
        chk("rst_frame_err", frame_err,  0);

        // Make code 0x1C with exact valid timing after the stop-bit edge.
        event_ready = 1'b1;
        fr = frame_of(8'h1C, 1'b0, 1'b1);
        send_bits(fr, 10);
        ps2data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("lat_valid_early", event_valid, 0);
        @(negedge clk);
        chk("lat_valid",  event_valid, 1);
        chk("lat_code",   event_code,  8'h1C);
        chk("lat_ext",    event_ext,   0);
        chk("lat_break",  event_break, 0);
        @(negedge clk);
        chk("lat_pulse_end", event_valid, 0);
        repeat (HALF - LAT - 2) @(negedge clk);
        ps2clk = 1'b1;
        repeat (HALF) @(negedge clk);

        // Break code F0 1C.
        base = got.size();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("brk_count", got.size() - base, 1);
        chk("brk_event", got[base], {2'b01, 8'h1C});

        // Extended break E0 F0 75, then a plain make proves the decoder is idle.
        base = got.size();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("extbrk_count", got.size() - base, 1);
        chk("extbrk_event", got[base], {2'b11, 8'h75});
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("extbrk_idle", got[base + 1], {2'b00, 8'h1C});

        // Fill the 4-deep FIFO with no consumer, then overflow on the fifth.
        event_ready = 1'b0;
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'h1E, 1'b0, 1'b1);
        send_frame(8'h26, 1'b0, 1'b1);
        send_frame(8'h25, 1'b0, 1'b1);
        chk("full_no_ovf", overflow, 0);
        chk("full_head",   event_code, 8'h16);
        send_frame(8'h2E, 1'b0, 1'b1);
        chk("ovf_set", overflow, 1);
        base = got.size();
        event_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("drain_count", got.size() - base, 4);
        chk("drain_0", got[base],     {2'b00, 8'h16});
        chk("drain_1", got[base + 1], {2'b00, 8'h1E});
        chk("drain_2", got[base + 2], {2'b00, 8'h26});
        chk("drain_3", got[base + 3], {2'b00, 8'h25});
        chk("drain_empty", event_valid, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Wrong parity on 0x1C.
        base  = got.size();
        fbase = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_events", got.size() - base, 0);
        chk("par_ferr",   ferr_cnt - fbase, 1);
`else
        chk("par_events", got.size() - base, 1);
        chk("par_event",  got[base], {2'b00, 8'h1C});
        chk("par_ferr",   ferr_cnt - fbase, 0);
`endif

        // Stop bit of 0 is discarded with a frame error.
        base  = got.size();
        fbase = ferr_cnt;
        send_frame(8'h33, 1'b0, 1'b0);
        chk("stop_events", got.size() - base, 0);
        chk("stop_ferr",   ferr_cnt - fbase, 1);

        // A high start bit is ignored silently; the next frame still aligns.
        base  = got.size();
        fbase = ferr_cnt;
        ps2_bit(1'b1);
        ps2data = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("start1_ferr", ferr_cnt - fbase, 0);
        send_frame(8'h24, 1'b0, 1'b1);
        chk("start1_event", got[base], {2'b00, 8'h24});

        // Partial frame then timeout, followed by a good 0x29.
        base  = got.size();
        fbase = ferr_cnt;
        send_bits(frame_of(8'h5A, 1'b0, 1'b1), 5);
        ps2data = 1'b1;
        repeat (TIMEOUT_CYC + 1) @(negedge clk);
        chk("to_ferr", ferr_cnt - fbase, 1);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("to_count", got.size() - base, 1);
        chk("to_event", got[base], {2'b00, 8'h29});

        // Reset in the middle of a prefix and in the middle of a frame.
        send_frame(8'hE0, 1'b0, 1'b1);
        do_reset();
        base = got.size();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("rst_prefix", got[base], {2'b00, 8'h1C});
        send_bits(frame_of(8'hF0, 1'b0, 1'b1), 4);
        ps2data = 1'b1;
        do_reset();
        base = got.size();
        send_frame(8'h29, 1'b0, 1'b1);
        chk("rst_frame_count", got.size() - base, 1);
        chk("rst_frame_event", got[base], {2'b00, 8'h29});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
